// File: rtl/tdc_coarse_if.sv
// Measurement handshake bundle between the TDC coarse counter and its
// neighbours: edge pulses from the trigger filters, the result bus towards
// the readout/fine-time merge, and status flags.
// master: upstream/downstream environment. slave: the coarse counter.
interface tdc_coarse_if #(
  parameter int CNT_W = 16
);
  logic             start_pulse;
  logic             stop_pulse;
  logic             meas_ready;
  logic [CNT_W-1:0] meas_data;
  logic             meas_valid;
  logic             overflow;
  logic             timeout;
  logic             busy;
  logic             miss;

  modport master (
    output start_pulse, stop_pulse, meas_ready,
    input  meas_data, meas_valid, overflow, timeout, busy, miss
  );

  modport slave (
    input  start_pulse, stop_pulse, meas_ready,
    output meas_data, meas_valid, overflow, timeout, busy, miss
  );
endinterface

// File: rtl/tdc_coarse_counter.sv
// Coarse-time stage of the TDC: counts clk cycles between a start and a stop
// pulse and holds the result on a valid/ready interface until accepted.
// One measurement is in flight at a time. A start arriving in the handshake
// cycle launches the next measurement immediately, so the interface keeps
// up with one measurement every two cycles.
// Optional feature: define COARSE_TIMEOUT_EN to abort a measurement after
// TIMEOUT cycles without a stop (result TIMEOUT, timeout flag set).
// All outputs come straight from flops.
module tdc_coarse_counter #(
  parameter int CNT_W   = 16,
  parameter int TIMEOUT = 1000
) (
  input  logic         clk,
  input  logic         rst,
  tdc_coarse_if.slave  bus
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    HOLD = 2'd2
  } state_t;

  localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};
  localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};
  localparam logic [CNT_W-1:0] TO_LAST = CNT_W'(TIMEOUT - 1);
  localparam logic [CNT_W-1:0] TO_VAL  = CNT_W'(TIMEOUT);

`ifdef COARSE_TIMEOUT_EN
  localparam logic TIMEOUT_ON = 1'b1;
`else
  localparam logic TIMEOUT_ON = 1'b0;
`endif

  state_t           state_r;
  logic [CNT_W-1:0] cnt_r;
  logic [CNT_W-1:0] data_r;
  logic             valid_r;
  logic             ovf_r;
  logic             to_r;
  logic             busy_r;
  logic             miss_r;
  logic             hshk_s;

  // Saturating increment: the counter clamps at all-ones and never wraps.
  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    if (v == CNT_MAX) begin
      return CNT_MAX;
    end else begin
      return v + CNT_ONE;
    end
  endfunction

  assign hshk_s = valid_r & bus.meas_ready;

  // Measurement FSM with all outputs registered alongside the state.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r <= IDLE;
      cnt_r   <= '0;
      data_r  <= '0;
      valid_r <= 1'b0;
      ovf_r   <= 1'b0;
      to_r    <= 1'b0;
      busy_r  <= 1'b0;
      miss_r  <= 1'b0;
    end else begin
      miss_r <= 1'b0;
      case (state_r)
        IDLE: begin
          // Start wins over a coincident stop; a lone stop is ignored.
          if (bus.start_pulse) begin
            cnt_r   <= '0;
            busy_r  <= 1'b1;
            state_r <= RUN;
          end else begin
            state_r <= IDLE;
          end
        end
        RUN: begin
          // A stop has priority over the timeout check in the same cycle.
          if (bus.stop_pulse) begin
            data_r  <= sat_inc(cnt_r);
            ovf_r   <= (cnt_r == CNT_MAX);
            to_r    <= 1'b0;
            valid_r <= 1'b1;
            busy_r  <= 1'b0;
            state_r <= HOLD;
          end else if (TIMEOUT_ON && (cnt_r == TO_LAST)) begin
            data_r  <= TO_VAL;
            ovf_r   <= 1'b0;
            to_r    <= 1'b1;
            valid_r <= 1'b1;
            busy_r  <= 1'b0;
            state_r <= HOLD;
          end else begin
            cnt_r   <= sat_inc(cnt_r);
          end
        end
        HOLD: begin
          // Result frozen until accepted; a start during the stall is lost.
          if (hshk_s) begin
            valid_r <= 1'b0;
            if (bus.start_pulse) begin
              cnt_r   <= '0;
              busy_r  <= 1'b1;
              state_r <= RUN;
            end else begin
              state_r <= IDLE;
            end
          end else if (bus.start_pulse) begin
            miss_r <= 1'b1;
          end else begin
            state_r <= HOLD;
          end
        end
        default: begin
          state_r <= IDLE;
          valid_r <= 1'b0;
          busy_r  <= 1'b0;
        end
      endcase
    end
  end

  assign bus.meas_data  = data_r;
  assign bus.meas_valid = valid_r;
  assign bus.overflow   = ovf_r;
  assign bus.timeout    = to_r;
  assign bus.busy       = busy_r;
  assign bus.miss       = miss_r;

endmodule

// File: tb/tb_tdc_coarse_counter.sv
// Scoreboard bench for tdc_coarse_counter. Stimulus pushes the expected
// result of each measurement into a per-instance queue; monitors pop and
// compare on every accepted result. Instance a: CNT_W=16, instance b:
// CNT_W=4 for saturation, instance c (COARSE_TIMEOUT_EN only): TIMEOUT=8.
module tb_tdc_coarse_counter;

  logic clk = 1'b0;
  logic rst;

  // Free-running measurement clock.
  always #5 clk = ~clk;

  tdc_coarse_if #(.CNT_W(16)) a_if ();
  tdc_coarse_if #(.CNT_W(4))  b_if ();

  tdc_coarse_counter #(.CNT_W(16), .TIMEOUT(1000)) dut_a (
    .clk(clk), .rst(rst), .bus(a_if.slave)
  );
  tdc_coarse_counter #(.CNT_W(4), .TIMEOUT(15)) dut_b (
    .clk(clk), .rst(rst), .bus(b_if.slave)
  );

`ifdef COARSE_TIMEOUT_EN
  tdc_coarse_if #(.CNT_W(16)) c_if ();
  tdc_coarse_counter #(.CNT_W(16), .TIMEOUT(8)) dut_c (
    .clk(clk), .rst(rst), .bus(c_if.slave)
  );
`endif

  typedef struct packed {
    logic [15:0] data;
    logic        ovf;
    logic        to;
  } exp_t;

  exp_t qa[$];
  exp_t qb[$];
  exp_t qc[$];
  int   vec  = 0;
  int   errs = 0;

  function automatic void chk(string name, logic [31:0] act, logic [31:0] exp);
    vec++;
    if (act !== exp) begin
      errs++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endfunction

  function automatic exp_t mk(int d, bit o, bit t);
    exp_t e;
    e.data = d[15:0];
    e.ovf  = o;
    e.to   = t;
    return e;
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Scoreboard for instance a: compare every accepted result.
  always @(negedge clk) begin
    if (a_if.meas_valid && a_if.meas_ready) begin
      if (qa.size() == 0) begin
        chk("a_unexpected_result", 32'd1, 32'd0);
      end else begin
        exp_t e;
        e = qa.pop_front();
        chk("a_data", a_if.meas_data, e.data);
        chk("a_overflow", a_if.overflow, e.ovf);
        chk("a_timeout", a_if.timeout, e.to);
      end
    end
  end

  // Scoreboard for instance b.
  always @(negedge clk) begin
    if (b_if.meas_valid && b_if.meas_ready) begin
      if (qb.size() == 0) begin
        chk("b_unexpected_result", 32'd1, 32'd0);
      end else begin
        exp_t e;
        e = qb.pop_front();
        chk("b_data", b_if.meas_data, e.data);
        chk("b_overflow", b_if.overflow, e.ovf);
        chk("b_timeout", b_if.timeout, e.to);
      end
    end
  end

`ifdef COARSE_TIMEOUT_EN
  // Scoreboard for instance c.
  always @(negedge clk) begin
    if (c_if.meas_valid && c_if.meas_ready) begin
      if (qc.size() == 0) begin
        chk("c_unexpected_result", 32'd1, 32'd0);
      end else begin
        exp_t e;
        e = qc.pop_front();
        chk("c_data", c_if.meas_data, e.data);
        chk("c_overflow", c_if.overflow, e.ovf);
        chk("c_timeout", c_if.timeout, e.to);
      end
    end
  end
`endif

  // Start at edge N, stop at edge N+k on instance a.
  task automatic a_interval(int k);
    a_if.start_pulse = 1'b1;
    step();
    a_if.start_pulse = 1'b0;
    chk("busy_after_start", a_if.busy, 32'd1);
    repeat (k - 1) step();
    chk("busy_before_stop", a_if.busy, 32'd1);
    chk("valid_before_stop", a_if.meas_valid, 32'd0);
    a_if.stop_pulse = 1'b1;
    step();
    a_if.stop_pulse = 1'b0;
    chk("valid_after_stop", a_if.meas_valid, 32'd1);
    chk("busy_after_stop", a_if.busy, 32'd0);
  endtask

  // Directed stimulus sequence.
  initial begin
    rst = 1'b1;
    a_if.start_pulse = 1'b0; a_if.stop_pulse = 1'b0; a_if.meas_ready = 1'b0;
    b_if.start_pulse = 1'b0; b_if.stop_pulse = 1'b0; b_if.meas_ready = 1'b0;
`ifdef COARSE_TIMEOUT_EN
    c_if.start_pulse = 1'b0; c_if.stop_pulse = 1'b0; c_if.meas_ready = 1'b0;
`endif
    step();
    step();
    rst = 1'b0;

    // Reset values.
    chk("rst_valid", a_if.meas_valid, 32'd0);
    chk("rst_data", a_if.meas_data, 32'd0);
    chk("rst_busy", a_if.busy, 32'd0);
    chk("rst_miss", a_if.miss, 32'd0);
    chk("rst_overflow", a_if.overflow, 32'd0);
    chk("rst_timeout", a_if.timeout, 32'd0);
    repeat (5) step();

    // Basic interval of 37 with ready held high.
    a_if.meas_ready = 1'b1;
    qa.push_back(mk(37, 1'b0, 1'b0));
    a_interval(37);
    step();
    chk("basic_valid_drops", a_if.meas_valid, 32'd0);

    // Backpressure: 20-cycle stall with a dropped start, then start on handshake.
    a_if.meas_ready = 1'b0;
    qa.push_back(mk(12, 1'b0, 1'b0));
    a_interval(12);
    for (int i = 0; i < 20; i++) begin
      if (i == 5) a_if.start_pulse = 1'b1;
      step();
      a_if.start_pulse = 1'b0;
      chk("stall_valid", a_if.meas_valid, 32'd1);
      chk("stall_data", a_if.meas_data, 32'd12);
      chk("stall_miss", a_if.miss, (i == 5) ? 32'd1 : 32'd0);
    end
    qa.push_back(mk(5, 1'b0, 1'b0));
    a_if.meas_ready  = 1'b1;
    a_if.start_pulse = 1'b1;
    step();
    a_if.start_pulse = 1'b0;
    chk("hshk_valid_drops", a_if.meas_valid, 32'd0);
    chk("hshk_start_busy", a_if.busy, 32'd1);
    chk("hshk_no_miss", a_if.miss, 32'd0);
    repeat (4) step();
    a_if.stop_pulse = 1'b1;
    step();
    a_if.stop_pulse = 1'b0;
    chk("b2b_valid", a_if.meas_valid, 32'd1);
    step();

    // Start and stop together in IDLE; stop at +3.
    qa.push_back(mk(3, 1'b0, 1'b0));
    a_if.start_pulse = 1'b1;
    a_if.stop_pulse  = 1'b1;
    step();
    a_if.start_pulse = 1'b0;
    a_if.stop_pulse  = 1'b0;
    chk("simul_busy", a_if.busy, 32'd1);
    step();
    step();
    a_if.stop_pulse = 1'b1;
    step();
    a_if.stop_pulse = 1'b0;
    chk("simul_valid", a_if.meas_valid, 32'd1);
    step();

    // Stop in IDLE produces nothing.
    a_if.stop_pulse = 1'b1;
    step();
    a_if.stop_pulse = 1'b0;
    step();
    chk("idle_stop_valid", a_if.meas_valid, 32'd0);
    chk("idle_stop_busy", a_if.busy, 32'd0);

    // Extra start in RUN does not restart the count; interval 6.
    qa.push_back(mk(6, 1'b0, 1'b0));
    a_if.start_pulse = 1'b1;
    step();
    a_if.start_pulse = 1'b0;
    step();
    a_if.start_pulse = 1'b1;
    step();
    a_if.start_pulse = 1'b0;
    chk("run_start_no_miss", a_if.miss, 32'd0);
    chk("run_start_busy", a_if.busy, 32'd1);
    repeat (3) step();
    a_if.stop_pulse = 1'b1;
    step();
    a_if.stop_pulse = 1'b0;
    chk("run_start_valid", a_if.meas_valid, 32'd1);
    step();

    // Reset in the middle of RUN.
    a_if.start_pulse = 1'b1;
    step();
    a_if.start_pulse = 1'b0;
    repeat (4) step();
    rst = 1'b1;
    step();
    rst = 1'b0;
    chk("rst_run_busy", a_if.busy, 32'd0);
    chk("rst_run_valid", a_if.meas_valid, 32'd0);
    chk("rst_run_data", a_if.meas_data, 32'd0);

    // Reset while a result is held; pending result is discarded.
    a_if.meas_ready = 1'b0;
    a_interval(7);
    rst = 1'b1;
    step();
    rst = 1'b0;
    chk("rst_hold_valid", a_if.meas_valid, 32'd0);
    chk("rst_hold_data", a_if.meas_data, 32'd0);
    a_if.meas_ready = 1'b1;
    qa.push_back(mk(4, 1'b0, 1'b0));
    a_interval(4);
    step();

    // Saturation on the 4-bit instance: stop 20 cycles after start.
    b_if.start_pulse = 1'b1;
    step();
    b_if.start_pulse = 1'b0;
    repeat (19) step();
    b_if.stop_pulse = 1'b1;
    step();
    b_if.stop_pulse = 1'b0;
    chk("sat_valid", b_if.meas_valid, 32'd1);
`ifdef COARSE_TIMEOUT_EN
    qb.push_back(mk(15, 1'b0, 1'b1));
`else
    qb.push_back(mk(15, 1'b1, 1'b0));
`endif
    b_if.meas_ready = 1'b1;
    step();
    chk("sat_valid_drops", b_if.meas_valid, 32'd0);

`ifdef COARSE_TIMEOUT_EN
    // Timeout after 8 cycles without a stop.
    c_if.meas_ready = 1'b1;
    qc.push_back(mk(8, 1'b0, 1'b1));
    c_if.start_pulse = 1'b1;
    step();
    c_if.start_pulse = 1'b0;
    repeat (7) step();
    chk("to_not_yet", c_if.meas_valid, 32'd0);
    step();
    chk("to_valid", c_if.meas_valid, 32'd1);
    step();
    // Stop in the timeout cycle wins.
    qc.push_back(mk(8, 1'b0, 1'b0));
    c_if.start_pulse = 1'b1;
    step();
    c_if.start_pulse = 1'b0;
    repeat (7) step();
    c_if.stop_pulse = 1'b1;
    step();
    c_if.stop_pulse = 1'b0;
    chk("to_stop_valid", c_if.meas_valid, 32'd1);
    step();
`endif

    step();
    step();
    chk("a_queue_drained", qa.size(), 32'd0);
    chk("b_queue_drained", qb.size(), 32'd0);
    chk("c_queue_drained", qc.size(), 32'd0);
    $display("== %0d vectors applied, %0d miscompares ==", vec, errs);
    $finish;
  end

endmodule
